aes_key_expander: RTL and testbench

Iterative AES key-schedule engine that sits directly upstream of the round-key memory (`keymem`). It accepts a 128- or 256-bit cipher key over a valid/ready handshake, clears the memory's valid bits, then produces the round keys one 32-bit word per cycle. It writes each completed 128-bit round key into `keymem` through its `w_en`/`waddr`/`wkey`/`reset_valid_bits` port set: 11 round keys for AES-128, 15 for AES-256.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_sbox.sv | 30 +++
 rtl/aes_key_expander.sv | 181 ++++++++++++++++++
 tb/tb_aes_key_expander.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES key-schedule engine and its S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    GEN,
    DONE
  } state_t;

  localparam int NK128 = 4;
  localparam int NK256 = 8;
  localparam int NR128 = 10;
  localparam int NR256 = 14;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  // Multiply by x in GF(2^8), used to step the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Entry for input byte b sits at bits [8*(255-b)+7 : 8*(255-b)] of the table,
// so the select offset is simply {~b, 3'b000}.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX_TABLE[{~din, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/256 key schedule: one 32-bit word per cycle, each finished
// 128-bit round key written to the round-key memory the cycle after its last word.
// The word window holds the most recent Nk words in its upper slots (win[7] newest),
// so w[i-1] is always win[7] and w[i-Nk] is win[0] (AES-256) or win[4] (AES-128).
module aes_key_expander
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         reset_valid_bits,
  output logic         w_en,
  output logic [3:0]   waddr,
  output logic [127:0] wkey
);

  state_t state, next_state;

  logic [31:0]  win [8];
  logic         len256;
  logic [7:0]   rcon;
  logic [5:0]   word_idx;

  logic         accept;
  logic [5:0]   gen_end;
  logic         word_valid;
  logic         key_step;
  logic         sub_step;
  logic [31:0]  rot_word;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp_word;
  logic [31:0]  new_word;

  logic         busy_d;
  logic         done_d;
  logic         rvb_d;
  logic         w_en_d;
  logic [3:0]   waddr_d;
  logic [127:0] wkey_d;

  assign key_ready  = resetn & (state == IDLE);
  assign accept     = key_valid & key_ready;
  assign gen_end    = len256 ? 6'(4 * NR256 + 4) : 6'(4 * NR128 + 4);
  assign word_valid = (state == GEN) && (word_idx < gen_end);
  assign key_step   = len256 ? (word_idx[2:0] == 3'd0) : (word_idx[1:0] == 2'd0);
  assign sub_step   = len256 && (word_idx[2:0] == 3'd4);
  assign rot_word   = {win[7][23:0], win[7][31:24]};
  assign sub_in     = key_step ? rot_word : win[7];

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .din  (sub_in[8*b +: 8]),
      .dout (sub_out[8*b +: 8])
    );
  end

  // Next schedule word from w[i-1] and w[i-Nk].
  always_comb begin
    temp_word = win[7];
    if (key_step) begin
      temp_word = sub_out ^ {rcon, 24'h000000};
    end else if (sub_step) begin
      temp_word = sub_out;
    end
    new_word = (len256 ? win[0] : win[4]) ^ temp_word;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; GEN lingers one cycle past the last word to issue its write.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CLEAR;
      CLEAR:   next_state = GEN;
      GEN:     if (word_idx == gen_end) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs; round keys 0 (and 1 for AES-256) come straight from the key.
  always_comb begin
    busy_d  = (next_state == CLEAR) || (next_state == GEN);
    done_d  = (next_state == DONE);
    rvb_d   = (next_state == CLEAR);
    w_en_d  = 1'b0;
    waddr_d = waddr;
    wkey_d  = wkey;
    case (state)
      CLEAR: begin
        w_en_d  = 1'b1;
        waddr_d = 4'd0;
        wkey_d  = len256 ? {win[0], win[1], win[2], win[3]}
                         : {win[4], win[5], win[6], win[7]};
      end
      GEN: begin
        if (len256 && (word_idx == 6'(NK256))) begin
          w_en_d  = 1'b1;
          waddr_d = 4'd1;
          wkey_d  = {win[4], win[5], win[6], win[7]};
        end else if (word_valid && (word_idx[1:0] == 2'd3)) begin
          w_en_d  = 1'b1;
          waddr_d = word_idx[5:2];
          wkey_d  = {win[5], win[6], win[7], new_word};
        end
      end
      default: ;
    endcase
  end

  // Registered outputs toward the round-key memory and the handshake side.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      reset_valid_bits <= 1'b0;
      w_en             <= 1'b0;
      waddr            <= 4'd0;
      wkey             <= '0;
    end else begin
      busy             <= busy_d;
      done             <= done_d;
      reset_valid_bits <= rvb_d;
      w_en             <= w_en_d;
      waddr            <= waddr_d;
      wkey             <= wkey_d;
    end
  end

  // Key latch, word window shift, word counter and round constant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 8; k++) win[k] <= '0;
      len256   <= 1'b0;
      rcon     <= 8'h00;
      word_idx <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            len256   <= key_len;
            rcon     <= RCON_INIT;
            word_idx <= key_len ? 6'(NK256) : 6'(NK128);
            if (key_len) begin
              for (int k = 0; k < 8; k++) win[k] <= key_in[255 - 32*k -: 32];
            end else begin
              for (int k = 0; k < 4; k++) begin
                win[k]     <= '0;
                win[k + 4] <= key_in[255 - 32*k -: 32];
              end
            end
          end
        end
        GEN: begin
          word_idx <= word_idx + 6'd1;
          if (word_valid) begin
            for (int k = 0; k < 7; k++) win[k] <= win[k + 1];
            win[7] <= new_word;
            if (key_step) rcon <= xtime(rcon);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: a cycle-timeline reference model of the
// key schedule, a per-cycle compare process, a keymem model, and directed FIPS-197 runs.
module tb_aes_key_expander;

  localparam logic [255:0] K128A = 256'h2b7e151628aed2a6abf7158809cf4f3c_deadbeefcafef00d0123456789abcdef;
  localparam logic [255:0] K128B = 256'h000102030405060708090a0b0c0d0e0f_ffffffffffffffffffffffffffffffff;
  localparam logic [255:0] K256A = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_len = 1'b0;
  logic [255:0] key_in = '0;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic         reset_valid_bits;
  logic         w_en;
  logic [3:0]   waddr;
  logic [127:0] wkey;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  aes_key_expander dut (
    .clk              (clk),
    .resetn           (resetn),
    .key_valid        (key_valid),
    .key_ready        (key_ready),
    .key_len          (key_len),
    .key_in           (key_in),
    .busy             (busy),
    .done             (done),
    .reset_valid_bits (reset_valid_bits),
    .w_en             (w_en),
    .waddr            (waddr),
    .wkey             (wkey)
  );

  // Compare one value against its expectation and log a failure line if they differ.
  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Reference S-box built from the GF(2^8) inverse and the affine map, independent of any table.
  logic [7:0] sbox_ref [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    logic [7:0] r;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
      end
      r = inv;
      sbox_ref[b] = inv ^ 8'h63;
      for (int s = 0; s < 4; s++) begin
        r = rotl8(r);
        sbox_ref[b] = sbox_ref[b] ^ r;
      end
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] x);
    return {sbox_ref[x[31:24]], sbox_ref[x[23:16]], sbox_ref[x[15:8]], sbox_ref[x[7:0]]};
  endfunction

  // Full key expansion into round keys, straight from the FIPS-197 recurrence.
  logic [127:0] m_rk [15];

  task automatic expandKey(input logic [255:0] k, input logic l);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    int nr;
    nk = l ? 8 : 4;
    nr = l ? 14 : 10;
    rc = 8'h01;
    for (int j = 0; j < 60; j++) w[j] = '0;
    for (int j = 0; j < nk; j++) w[j] = k[255 - 32*j -: 32];
    for (int j = nk; j < 4*nr + 4; j++) begin
      t = w[j-1];
      if (j % nk == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && j % 8 == 4) begin
        t = subWord(t);
      end
      w[j] = w[j-nk] ^ t;
    end
    for (int n = 0; n < 15; n++) begin
      m_rk[n] = (n <= nr) ? {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]} : '0;
    end
  endtask

  // Cycle (relative to acceptance) at which each round key index must be written, else -1.
  function automatic int writeIdx(input int t, input logic l);
    if (!l) begin
      if (t >= 2 && (t - 2) % 4 == 0 && (t - 2) / 4 <= 10) return (t - 2) / 4;
    end else begin
      if (t == 2) return 0;
      if (t == 3) return 1;
      if (t >= 6 && (t + 2) % 4 == 0 && (t + 2) / 4 <= 14) return (t + 2) / 4;
    end
    return -1;
  endfunction

  function automatic int doneT(input logic l);
    return l ? 55 : 43;
  endfunction

  // Reference timeline: tracks acceptance, the cycle offset and the held write port values.
  bit           m_active = 1'b0;
  int           m_t = 0;
  logic         m_len = 1'b0;
  logic [3:0]   m_waddr = 4'd0;
  logic [127:0] m_wkey = '0;

  always @(posedge clk or negedge resetn) begin : model
    int wi;
    if (!resetn) begin
      m_active = 1'b0;
      m_t      = 0;
      m_waddr  = 4'd0;
      m_wkey   = '0;
    end else if (!m_active) begin
      if (key_valid) begin
        expandKey(key_in, key_len);
        m_len    = key_len;
        m_active = 1'b1;
        m_t      = 1;
      end
    end else if (m_t == doneT(m_len)) begin
      m_active = 1'b0;
    end else begin
      m_t++;
      wi = writeIdx(m_t, m_len);
      if (wi >= 0) begin
        m_waddr = 4'(wi);
        m_wkey  = m_rk[wi];
      end
    end
  end

  // Per-cycle comparison of every DUT output against the reference timeline.
  always @(negedge clk) begin : cmp
    int wi;
    if (check_en) begin
      wi = m_active ? writeIdx(m_t, m_len) : -1;
      checkOutput("key_ready", 128'(key_ready), 128'(resetn && !m_active));
      checkOutput("busy", 128'(busy), 128'(m_active && (m_t < doneT(m_len))));
      checkOutput("done", 128'(done), 128'(m_active && (m_t == doneT(m_len))));
      checkOutput("reset_valid_bits", 128'(reset_valid_bits), 128'(m_active && (m_t == 1)));
      checkOutput("w_en", 128'(w_en), 128'(wi >= 0));
      checkOutput("waddr", 128'(waddr), 128'(m_waddr));
      checkOutput("wkey", wkey, m_wkey);
    end
  end

  // Round-key memory model: clear has priority over write.
  logic [14:0]  km_valid = '0;
  logic [127:0] km_mem [15];

  always @(posedge clk) begin
    if (reset_valid_bits) begin
      km_valid <= '0;
    end else if (w_en) begin
      km_valid[waddr] <= 1'b1;
      km_mem[waddr]   <= wkey;
    end
  end

  // Offer a key; returns just after the acceptance edge.
  task automatic applyStimulus(input logic [255:0] k, input logic l, input bit hold);
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_in    = k;
    key_len   = l;
    @(posedge clk);
    #1;
    if (!hold) key_valid = 1'b0;
  endtask

  // Wait (bounded) for done, counting cycles from acceptance; sample a few probes on the way.
  task automatic waitDone(input string tag, input int exp_c, input bit scramble, input int probe_c,
                          output logic rvb1, output logic probe_wen, output logic [127:0] probe_wkey,
                          output logic [14:0] valid_at2);
    int seen_at;
    seen_at    = -1;
    rvb1       = 1'b0;
    probe_wen  = 1'b0;
    probe_wkey = '0;
    valid_at2  = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) rvb1 = reset_valid_bits;
      if (c == 2) valid_at2 = km_valid;
      if (c == probe_c) begin
        probe_wen  = w_en;
        probe_wkey = wkey;
      end
      if (done) begin
        seen_at = c;
        break;
      end
      if (scramble) key_in = {$urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom(), $urandom()};
    end
    checkOutput({tag, "_done_cycle"}, 128'(seen_at), 128'(exp_c));
  endtask

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    logic         rvb1;
    logic         pwen;
    logic [127:0] pkey;
    logic [14:0]  v2;

    buildSbox();
    repeat (3) @(posedge clk);
    check_en = 1'b1;
    #1 resetn = 1'b1;
    @(negedge clk);
    checkOutput("reset_key_ready", 128'(key_ready), 128'(1'b1));
    checkOutput("reset_busy", 128'(busy), 128'(1'b0));
    checkOutput("reset_wkey", wkey, 128'h0);

    // AES-128 FIPS-197 key, with garbage in the ignored lower half.
    applyStimulus(K128A, 1'b0, 1'b0);
    checkOutput("model128_rk0", m_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    checkOutput("model128_rk1", m_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    checkOutput("model128_rk10", m_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    waitDone("aes128", 43, 1'b0, 6, rvb1, pwen, pkey, v2);
    checkOutput("aes128_clear_t1", 128'(rvb1), 128'(1'b1));
    checkOutput("aes128_wen_t6", 128'(pwen), 128'(1'b1));
    checkOutput("aes128_rk1_t6", pkey, 128'ha0fafe1788542cb123a339392a6c7605);

    // AES-256 FIPS-197 key.
    applyStimulus(K256A, 1'b1, 1'b0);
    checkOutput("model256_rk1", m_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
    checkOutput("model256_rk2", m_rk[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    checkOutput("model256_rk14", m_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
    waitDone("aes256", 55, 1'b0, 3, rvb1, pwen, pkey, v2);
    checkOutput("aes256_rk1_t3", pkey, 128'h1f352c073b6108d72d9810a30914dff4);

    // key_valid held high with a changing key: no re-acceptance, second key at T+44.
    applyStimulus(K128A, 1'b0, 1'b1);
    waitDone("held", 43, 1'b1, 6, rvb1, pwen, pkey, v2);
    checkOutput("held_rk1_t6", pkey, 128'ha0fafe1788542cb123a339392a6c7605);
    @(negedge clk);
    checkOutput("held_ready_t44", 128'(key_ready), 128'(1'b1));
    @(negedge clk);
    checkOutput("held_clear_t45", 128'(reset_valid_bits), 128'(1'b1));
    key_valid = 1'b0;
    waitDone("held_second", 42, 1'b0, 0, rvb1, pwen, pkey, v2);

    // Reset pulse at T+20, then a fresh key.
    applyStimulus(K128B, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    checkOutput("rst_busy", 128'(busy), 128'(1'b0));
    checkOutput("rst_w_en", 128'(w_en), 128'(1'b0));
    checkOutput("rst_waddr", 128'(waddr), 128'(4'd0));
    checkOutput("rst_wkey", wkey, 128'h0);
    checkOutput("rst_key_ready_low", 128'(key_ready), 128'(1'b0));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    checkOutput("rst_key_ready_high", 128'(key_ready), 128'(1'b1));
    applyStimulus(K128A, 1'b0, 1'b0);
    waitDone("after_rst", 43, 1'b0, 6, rvb1, pwen, pkey, v2);
    checkOutput("after_rst_clear_t1", 128'(rvb1), 128'(1'b1));
    checkOutput("after_rst_rk1_t6", pkey, 128'ha0fafe1788542cb123a339392a6c7605);

    // Back-to-back AES-256 then AES-128 with the keymem model observing.
    applyStimulus(K256A, 1'b1, 1'b0);
    waitDone("b2b256", 55, 1'b0, 0, rvb1, pwen, pkey, v2);
    checkOutput("b2b256_valid", 128'(km_valid), 128'(15'h7FFF));
    key_valid = 1'b1;
    key_len   = 1'b0;
    key_in    = K128B;
    @(posedge clk);
    @(posedge clk);
    #1 key_valid = 1'b0;
    checkOutput("modelC1_rk10", m_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    waitDone("b2b128", 43, 1'b0, 0, rvb1, pwen, pkey, v2);
    checkOutput("b2b128_clear_t1", 128'(rvb1), 128'(1'b1));
    checkOutput("b2b128_valid_cleared", 128'(v2), 128'(15'h0000));
    checkOutput("b2b128_valid_final", 128'(km_valid), 128'(15'h07FF));
    for (int n = 0; n <= 10; n++) begin
      checkOutput($sformatf("b2b128_keymem_%0d", n), km_mem[n], m_rk[n]);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
